uart_apb_fifo: RTL and testbench
================================

Name: uart_apb_fifo

Overview:
APB3 slave UART (8N1) with parametrised TX/RX FIFOs, programmable baud divisor, sticky error flags, maskable level interrupt and APB error response for unmapped addresses. Next generation of the team's APB UART; drops into the same peripheral slot (5-bit word-aligned window), with buffering and status the previous block lacked.

Parameters:
FIFO_DEPTH, 16, entries per FIFO; power of 2, 2..128
DIV_W, 16, baud divisor register width
DEF_DIV, 434, divisor after reset (clocks per bit; 50 MHz / 115200)

Ports:
pclk     in   1   clock; all logic rising-edge
preset   in   1   reset, synchronous, active-high
paddr    in   5   byte address; [4:2] selects register, [1:0] ignored
prdata   out  32  read data
pwdata   in   32  write data
psel     in   1   slave select
penable  in   1   access phase
pwrite   in   1   1 = write
pready   out  1   ready; constant 1 (zero wait states)
pslverr  out  1   error; 1 in access phase when paddr[4:2] > 4
irq      out  1   interrupt request, registered
uart_tx  out  1   serial out, idle high
uart_rx  in   1   serial in, asynchronous

Behaviour:
- Transfer fires when psel & penable; side effects (FIFO push/pop, W1C) happen exactly once, on that cycle. prdata combinational from paddr during access phase, 0 otherwise. Unmapped: pslverr=1, prdata=0, no side effect.
- Registers (offset): 0x00 DATA W: push pwdata[7:0] to TX FIFO; drop and set TX_OVF if full. R: pop RX FIFO, prdata[7:0]=head; if empty return 0, no pop.
- 0x04 STATUS RO except W1C: [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty [4] tx_busy [5] RX_OVF [6] TX_OVF [7] FRAME_ERR (sticky, write 1 clears) [15:8] tx_count [23:16] rx_count.
- 0x08 CTRL RW: [0] tx_en [1] rx_en; reset 0.
- 0x0C DIV RW: [DIV_W-1:0]; reset DEF_DIV; written values <2 stored as 2.
- 0x10 IRQ RW: [0] en_rx_lvl [1] en_tx_empty [2] en_err [15:8] rx_thr (1..FIFO_DEPTH; 0 treated as 1); reset 0.
- irq registered: (en_rx_lvl & rx_count>=rx_thr) | (en_tx_empty & tx_empty & !tx_busy) | (en_err & |{RX_OVF,TX_OVF,FRAME_ERR}); one cycle after condition.
- FIFOs: count width log2(FIFO_DEPTH)+1; pointers wrap modulo depth. Simultaneous push+pop: full -> both succeed, count unchanged; empty -> push succeeds, pop ignored.
- Bit timer reloads from DIV at each bit boundary; DIV writes mid-frame take effect at next reload.
- TX FSM IDLE/START/DATA/STOP: IDLE with tx_en & !tx_empty pops byte, enters START (uart_tx=0) next cycle. Each bit lasts DIV clocks; 8 data bits LSB first; STOP high DIV clocks, then IDLE (back-to-back frames, no extra idle). tx_busy=1 outside IDLE. Clearing tx_en mid-frame finishes current frame.
- RX: 2-FF synchroniser, reset 1. IDLE with rx_en: synced 1->0 edge -> START; wait DIV/2 (floor), resample; 1 -> IDLE (glitch, no flag). DATA: sample every DIV clocks, 8 bits LSB first. STOP: sample after DIV; 0 -> set FRAME_ERR, discard byte; 1 -> push to RX FIFO (full and no same-cycle pop -> drop, set RX_OVF). Return to IDLE right after stop sample. Clearing rx_en mid-frame finishes current frame.
- Reset: all FSMs IDLE, FIFOs empty, sticky flags 0, uart_tx=1, irq=0, prdata=0, pslverr=0, pready=1; applies next edge, including mid-frame (TX line high next cycle).

Test Plan:
- DIV=4, tx_en=1, write 0x55 then 0xA3 -> uart_tx: start, 10101010 LSB-first, stop, each bit 4 clocks, second frame immediately after; tx_empty=1, tx_busy=0 after 80 clocks.
- uart_tx looped to uart_rx, DIV=8, rx_en=tx_en=1, push 3 bytes -> rx_count=3, DATA reads return same bytes in order, then read of empty returns 0 with rx_count unchanged.
- FIFO_DEPTH=4, tx_en=0, write 5 bytes -> tx_full=1, TX_OVF=1, tx_count=4; write STATUS=0x40 -> TX_OVF=0.
- Drive rx frame with stop bit 0 -> FRAME_ERR=1, rx_count=0; 2-clock low glitch on uart_rx (DIV=8) -> no byte, no flag.
- IRQ=0x0201, receive 1 byte -> irq=0; second byte -> irq=1 one cycle after push; pop one -> irq=0.
- Access paddr=0x14 -> pslverr=1, prdata=0, no state change; assert preset mid-TX frame -> uart_tx=1, STATUS=0x0A next cycle.

Source files
------------

// File: rtl/uart_apb_fifo.sv
// APB3 UART (8N1) with TX/RX byte FIFOs, programmable divisor, sticky errors and level IRQ.
// Latency: APB zero wait states; TX frame starts the cycle after a byte is popped; RX byte pushed at the stop-bit sample.
// Backpressure: TX writes into a full FIFO are dropped (TX_OVF); received bytes hitting a full RX FIFO are dropped (RX_OVF).

// Byte FIFO: push into full succeeds only alongside a pop; pop from empty is ignored.
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [7:0]               i_dat,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_count   = r_cnt;
    assign o_head    = r_mem[r_rp];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | i_pop);

    // Storage array, written on every accepted push.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wp] <= i_dat;
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + AW'(1);
            if (w_pop_ok)  r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        end
    end
endmodule

module uart_apb_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int DEF_DIV    = 434
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic [4:0]  paddr,
    output logic [31:0] prdata,
    input  logic [31:0] pwdata,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    output logic        pready,
    output logic        pslverr,
    output logic        irq,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_t;

    // APB decode
    logic       w_acc, w_map, w_unused;
    logic [2:0] w_sel;
    assign w_acc    = psel & penable;
    assign w_sel    = paddr[4:2];
    assign w_map    = (w_sel <= 3'd4);
    assign pready   = 1'b1;
    assign pslverr  = w_acc & ~w_map;
    assign w_unused = ^{paddr[1:0], pwdata};

    logic w_wr, w_rd;
    assign w_wr = w_acc & pwrite;
    assign w_rd = w_acc & ~pwrite;

    // Control/config registers
    logic             r_tx_en, r_rx_en;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_irq_en;
    logic [7:0]       r_rx_thr;
    logic             r_rx_ovf, r_tx_ovf, r_ferr, r_irq;

    // FIFO hookup
    logic          w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic          w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0]    w_tx_head, w_rx_head;
    logic [CW-1:0] w_tx_cnt, w_rx_cnt;
    logic [7:0]    r_rx_sh;

    assign w_tx_push = w_wr & (w_sel == 3'd0);
    assign w_rx_pop  = w_rd & (w_sel == 3'd0) & ~w_rx_empty;

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk(pclk), .i_rst(preset), .i_push(w_tx_push), .i_dat(pwdata[7:0]), .i_pop(w_tx_pop),
        .o_head(w_tx_head), .o_count(w_tx_cnt), .o_full(w_tx_full), .o_empty(w_tx_empty)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk(pclk), .i_rst(preset), .i_push(w_rx_push), .i_dat(r_rx_sh), .i_pop(w_rx_pop),
        .o_head(w_rx_head), .o_count(w_rx_cnt), .o_full(w_rx_full), .o_empty(w_rx_empty)
    );

    // Transmitter
    uart_st_t         r_tx_st, w_tx_nxt;
    logic [DIV_W-1:0] r_tx_tmr;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_sh;
    logic             w_tx_tick, w_tx_busy;

    assign w_tx_tick = (r_tx_tmr == '0);
    assign w_tx_busy = (r_tx_st != ST_IDLE);
    assign uart_tx   = (r_tx_st == ST_START) ? 1'b0 :
                       (r_tx_st == ST_DATA)  ? r_tx_sh[0] : 1'b1;

    // TX state register
    always_ff @(posedge pclk) begin
        if (preset) r_tx_st <= ST_IDLE;
        else        r_tx_st <= w_tx_nxt;
    end

    // TX next state; a pending byte after the stop bit starts the next frame without an idle cycle
    always_comb begin
        w_tx_nxt = r_tx_st;
        w_tx_pop = 1'b0;
        case (r_tx_st)
            ST_IDLE: if (r_tx_en & ~w_tx_empty) begin
                w_tx_pop = 1'b1;
                w_tx_nxt = ST_START;
            end
            ST_START: if (w_tx_tick) w_tx_nxt = ST_DATA;
            ST_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_nxt = ST_STOP;
            ST_STOP:  if (w_tx_tick) begin
                if (r_tx_en & ~w_tx_empty) begin
                    w_tx_pop = 1'b1;
                    w_tx_nxt = ST_START;
                end else begin
                    w_tx_nxt = ST_IDLE;
                end
            end
            default: w_tx_nxt = ST_IDLE;
        endcase
    end

    // TX bit timer and shifter; timer reloads from DIV at every bit boundary
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_tx_tmr <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
        end else if (w_tx_pop) begin
            r_tx_sh  <= w_tx_head;
            r_tx_tmr <= r_div - DIV_W'(1);
            r_tx_bit <= '0;
        end else if (w_tx_busy) begin
            if (w_tx_tick) begin
                r_tx_tmr <= r_div - DIV_W'(1);
                if (r_tx_st == ST_DATA) begin
                    r_tx_sh  <= r_tx_sh >> 1;
                    r_tx_bit <= r_tx_bit + 3'd1;
                end
            end else begin
                r_tx_tmr <= r_tx_tmr - DIV_W'(1);
            end
        end
    end

    // Receiver
    uart_st_t         r_rx_st, w_rx_nxt;
    logic [DIV_W-1:0] r_rx_tmr;
    logic [2:0]       r_rx_bit;
    logic             r_rx_s1, r_rx_s2, r_rx_s3;
    logic             w_rx_tick, w_rx_fall, w_ferr;

    assign w_rx_tick = (r_rx_tmr == '0);
    assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge pclk) begin
        if (preset) r_rx_st <= ST_IDLE;
        else        r_rx_st <= w_rx_nxt;
    end

    // RX next state; a start bit that is high at mid-bit is treated as a glitch
    always_comb begin
        w_rx_nxt  = r_rx_st;
        w_rx_push = 1'b0;
        w_ferr    = 1'b0;
        case (r_rx_st)
            ST_IDLE:  if (r_rx_en & w_rx_fall) w_rx_nxt = ST_START;
            ST_START: if (w_rx_tick) w_rx_nxt = r_rx_s2 ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nxt = ST_STOP;
            ST_STOP:  if (w_rx_tick) begin
                w_rx_nxt  = ST_IDLE;
                w_rx_push = r_rx_s2;
                w_ferr    = ~r_rx_s2;
            end
            default: w_rx_nxt = ST_IDLE;
        endcase
    end

    // RX timer (half-bit to centre, then full bits) and LSB-first shifter
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_rx_tmr <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
        end else if (r_rx_st == ST_IDLE) begin
            r_rx_tmr <= (r_div >> 1) - DIV_W'(1);
            r_rx_bit <= '0;
        end else if (w_rx_tick) begin
            r_rx_tmr <= r_div - DIV_W'(1);
            if (r_rx_st == ST_DATA) begin
                r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                r_rx_bit <= r_rx_bit + 3'd1;
            end
        end else begin
            r_rx_tmr <= r_rx_tmr - DIV_W'(1);
        end
    end

    // Writable registers; divisor floored at 2
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_tx_en  <= 1'b0;
            r_rx_en  <= 1'b0;
            r_div    <= DIV_W'(DEF_DIV);
            r_irq_en <= '0;
            r_rx_thr <= '0;
        end else if (w_wr) begin
            case (w_sel)
                3'd2: {r_rx_en, r_tx_en} <= pwdata[1:0];
                3'd3: r_div <= (pwdata[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2) : pwdata[DIV_W-1:0];
                3'd4: begin
                    r_irq_en <= pwdata[2:0];
                    r_rx_thr <= pwdata[15:8];
                end
                default: ;
            endcase
        end
    end

    // Sticky error flags: W1C, a same-cycle new event wins over the clear
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_rx_ovf <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            if (w_wr && w_sel == 3'd1) begin
                if (pwdata[5]) r_rx_ovf <= 1'b0;
                if (pwdata[6]) r_tx_ovf <= 1'b0;
                if (pwdata[7]) r_ferr   <= 1'b0;
            end
            if (w_tx_push & w_tx_full & ~w_tx_pop) r_tx_ovf <= 1'b1;
            if (w_rx_push & w_rx_full & ~w_rx_pop) r_rx_ovf <= 1'b1;
            if (w_ferr) r_ferr <= 1'b1;
        end
    end

    // Registered interrupt; threshold 0 behaves as 1
    logic [7:0] w_thr;
    assign w_thr = (r_rx_thr == 8'd0) ? 8'd1 : r_rx_thr;
    assign irq   = r_irq;
    always_ff @(posedge pclk) begin
        if (preset) r_irq <= 1'b0;
        else r_irq <= (r_irq_en[0] & (8'(w_rx_cnt) >= w_thr))
                    | (r_irq_en[1] & w_tx_empty & ~w_tx_busy)
                    | (r_irq_en[2] & (r_rx_ovf | r_tx_ovf | r_ferr));
    end

    // Read mux, only driven during the access phase of a mapped address
    always_comb begin
        prdata = '0;
        if (w_acc) begin
            case (w_sel)
                3'd0: prdata = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
                3'd1: prdata = {8'd0, 8'(w_rx_cnt), 8'(w_tx_cnt), r_ferr, r_tx_ovf, r_rx_ovf,
                                w_tx_busy, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
                3'd2: prdata = {30'd0, r_rx_en, r_tx_en};
                3'd3: prdata = 32'(r_div);
                3'd4: prdata = {16'd0, r_rx_thr, 5'd0, r_irq_en};
                default: prdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_apb_fifo.sv
module tb_uart_apb_fifo;
    localparam int DEPTH = 4;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic [4:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] prdata;
    logic        pready, pslverr, irq, uart_tx, uart_rx;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;

    int checks = 0;
    int failures = 0;

    assign uart_rx = loop ? uart_tx : rx_drv;

    uart_apb_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DEF_DIV(434)) dut (
        .pclk(pclk), .preset(preset), .paddr(paddr), .prdata(prdata), .pwdata(pwdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pready(pready), .pslverr(pslverr),
        .irq(irq), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected STATUS word built from FIFO occupancies and flag states
    function automatic logic [31:0] stat(int txc, int rxc, bit busy, bit rxo, bit txo, bit fe);
        return {8'd0, 8'(rxc), 8'(txc), fe, txo, rxo, busy,
                (rxc == 0), (rxc == DEPTH), (txc == 0), (txc == DEPTH)};
    endfunction

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge pclk); #1;
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic e);
        @(posedge pclk); #1;
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        d = prdata;
        e = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        for (int i = 0; i < 10; i++) begin
            logic v;
            v = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
            @(posedge pclk); #1;
            rx_drv = v;
            repeat (div - 1) @(posedge pclk);
        end
        @(posedge pclk); #1;
        rx_drv = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge pclk); #1;
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [7:0]  q[$];
        logic [7:0]  tx_bytes[2];
        logic [7:0]  b;
        logic [3:0]  got;
        int          waited;
        int          seen;
        logic        irq_at, irq_after;

        // Reset state
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_pready", 32'(pready), 32'd1);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        apb_read(5'h04, d, e); check("rst_status", d, 32'h0000000A);
        apb_read(5'h0C, d, e); check("rst_div", d, 32'd434);
        apb_read(5'h08, d, e); check("rst_ctrl", d, 32'd0);
        apb_read(5'h10, d, e); check("rst_irqreg", d, 32'd0);

        // Divisor floor
        apb_write(5'h0C, 32'd1);
        apb_read(5'h0C, d, e); check("div_floor", d, 32'd2);

        // TX waveform: two frames back to back at DIV=4
        tx_bytes[0] = 8'h55;
        tx_bytes[1] = 8'hA3;
        apb_write(5'h0C, 32'd4);
        apb_write(5'h00, 32'(tx_bytes[0]));
        apb_write(5'h00, 32'(tx_bytes[1]));
        apb_write(5'h08, 32'd1);
        waited = 0;
        while (waited < 20) begin
            @(negedge pclk);
            if (uart_tx == 1'b0) break;
            waited++;
        end
        check("tx_start_latency", 32'(waited), 32'd1);
        for (int f = 0; f < 2; f++) begin
            for (int bit_i = 0; bit_i < 10; bit_i++) begin
                logic exp_bit;
                exp_bit = (bit_i == 0) ? 1'b0 : (bit_i == 9) ? 1'b1 : tx_bytes[f][bit_i-1];
                for (int c = 0; c < 4; c++) begin
                    if (!(f == 0 && bit_i == 0 && c == 0)) @(negedge pclk);
                    got[c] = uart_tx;
                end
                check($sformatf("tx_f%0d_bit%0d", f, bit_i), 32'(got), {28'd0, {4{exp_bit}}});
            end
        end
        apb_read(5'h04, d, e); check("tx_done_status", d, stat(0, 0, 0, 0, 0, 0));

        // Loopback with random bytes at DIV=8
        loop = 1'b1;
        apb_write(5'h0C, 32'd8);
        apb_write(5'h08, 32'd3);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            q.push_back(b);
            apb_write(5'h00, 32'(b));
        end
        repeat (400) @(posedge pclk);
        apb_read(5'h04, d, e); check("loop_status", d, stat(0, 3, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            apb_read(5'h00, d, e);
            check($sformatf("loop_byte%0d", i), d, 32'(q.pop_front()));
        end
        apb_read(5'h00, d, e); check("loop_empty_read", d, 32'd0);
        apb_read(5'h04, d, e); check("loop_empty_status", d, stat(0, 0, 0, 0, 0, 0));
        loop = 1'b0;

        // TX overflow with transmitter disabled
        do_reset();
        for (int i = 0; i < 5; i++) apb_write(5'h00, 32'($urandom_range(0, 255)));
        apb_read(5'h04, d, e); check("ovf_status", d, stat(4, 0, 0, 0, 1, 0));
        apb_write(5'h04, 32'h40);
        apb_read(5'h04, d, e); check("ovf_w1c", d, stat(4, 0, 0, 0, 0, 0));

        // Framing error, glitch rejection, good frame
        do_reset();
        apb_write(5'h0C, 32'd8);
        apb_write(5'h08, 32'd2);
        send_rx(8'($urandom_range(0, 255)), 1'b0, 8);
        repeat (10) @(posedge pclk);
        apb_read(5'h04, d, e); check("ferr_status", d, stat(0, 0, 0, 0, 0, 1));
        apb_write(5'h04, 32'h80);
        apb_read(5'h04, d, e); check("ferr_w1c", d, stat(0, 0, 0, 0, 0, 0));
        @(posedge pclk); #1 rx_drv = 1'b0;
        repeat (2) @(posedge pclk);
        #1 rx_drv = 1'b1;
        repeat (40) @(posedge pclk);
        apb_read(5'h04, d, e); check("glitch_status", d, stat(0, 0, 0, 0, 0, 0));
        b = 8'($urandom_range(0, 255));
        send_rx(b, 1'b1, 8);
        repeat (4) @(posedge pclk);
        apb_read(5'h00, d, e); check("rx_good_byte", d, 32'(b));

        // Interrupt on RX level threshold of 2
        apb_write(5'h10, 32'h0201);
        q.push_back(8'($urandom_range(0, 255)));
        send_rx(q[0], 1'b1, 8);
        repeat (4) @(posedge pclk);
        #1 check("irq_one_byte", 32'(irq), 32'd0);
        q.push_back(8'($urandom_range(0, 255)));
        seen = 0;
        irq_at = 1'bx;
        irq_after = 1'bx;
        fork
            send_rx(q[1], 1'b1, 8);
            begin
                @(posedge pclk); #1;
                paddr = 5'h04; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
                for (int k = 0; k < 300 && seen == 0; k++) begin
                    @(negedge pclk);
                    if (prdata[23:16] == 8'd2) begin
                        seen = 1;
                        irq_at = irq;
                        @(negedge pclk);
                        irq_after = irq;
                    end
                end
                psel = 1'b0; penable = 1'b0;
            end
        join
        check("irq_count_reached", 32'(seen), 32'd1);
        check("irq_at_push", 32'(irq_at), 32'd0);
        check("irq_after_push", 32'(irq_after), 32'd1);
        apb_read(5'h00, d, e); check("irq_pop_byte", d, 32'(q.pop_front()));
        @(posedge pclk); #1 check("irq_after_pop", 32'(irq), 32'd0);
        apb_write(5'h10, 32'h0001);
        @(posedge pclk); #1 check("irq_thr_zero", 32'(irq), 32'd1);
        apb_read(5'h00, d, e); check("irq_pop_last", d, 32'(q.pop_front()));
        @(posedge pclk); #1 check("irq_rx_empty", 32'(irq), 32'd0);
        apb_write(5'h10, 32'h0002);
        @(posedge pclk); #1 check("irq_tx_empty", 32'(irq), 32'd1);
        apb_write(5'h10, 32'h0000);

        // Unmapped access
        apb_read(5'h14, d, e);
        check("unmap_rd_err", 32'(e), 32'd1);
        check("unmap_rd_data", d, 32'd0);
        apb_write(5'h14, 32'hFFFF_FFFF);
        apb_read(5'h08, d, e);
        check("unmap_ctrl_kept", d, 32'd2);
        check("mapped_no_err", 32'(e), 32'd0);
        apb_read(5'h04, d, e); check("unmap_status_kept", d, stat(0, 0, 0, 0, 0, 0));

        // Reset in the middle of a TX frame
        apb_write(5'h08, 32'd1);
        apb_write(5'h00, 32'h00);
        repeat (20) @(posedge pclk);
        #1 check("tx_mid_low", 32'(uart_tx), 32'd0);
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
        check("rst_mid_tx_line", 32'(uart_tx), 32'd1);
        check("rst_mid_irq", 32'(irq), 32'd0);
        apb_read(5'h04, d, e); check("rst_mid_status", d, 32'h0000000A);
        apb_read(5'h0C, d, e); check("rst_mid_div", d, 32'd434);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
